// File: rtl/register_file.sv
// register_file: 2**ADDR_W x DATA_W general-purpose register file.
// Provides two combinational read ports that feed the ALU operands and two
// write ports: port A for the normal writeback and port B for the second
// destination of a swap. Register 0 always reads as zero.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a read of a
// register being written in the same cycle returns the new data. The default
// build (macro undefined) returns only the stored contents.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              swapWrite,
    input  logic [ADDR_W-1:0] swapReg,
    input  logic [DATA_W-1:0] swapData
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Effective write enables. Index 0 is never written. When both ports
    // target the same register, port A wins and port B is dropped.
    logic a_we;
    logic b_we;

    // Decode the effective write enables for both ports.
    always_comb begin
        a_we = regWrite && (writeReg != '0);
        b_we = swapWrite && (swapReg != '0) && !(a_we && (swapReg == writeReg));
    end

    // Storage update: reset clears every entry and overrides any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (b_we) begin
                regs[swapReg] <= swapData;
            end
            if (a_we) begin
                regs[writeReg] <= writeData;
            end
        end
    end

    // Read port 1: stored value, optionally forwarded from a same-cycle write.
    always_comb begin
        readData1 = '0;
        if (readReg1 != '0) begin
            readData1 = regs[readReg1];
`ifdef REGFILE_BYPASS_EN
            if (!reset) begin
                if (regWrite && (writeReg == readReg1)) begin
                    readData1 = writeData;
                end else if (swapWrite && (swapReg == readReg1)) begin
                    readData1 = swapData;
                end
            end
`endif
        end
    end

    // Read port 2: stored value, optionally forwarded from a same-cycle write.
    always_comb begin
        readData2 = '0;
        if (readReg2 != '0) begin
            readData2 = regs[readReg2];
`ifdef REGFILE_BYPASS_EN
            if (!reset) begin
                if (regWrite && (writeReg == readReg2)) begin
                    readData2 = writeData;
                end else if (swapWrite && (swapReg == readReg2)) begin
                    readData2 = swapData;
                end
            end
`endif
        end
    end

endmodule
